misr_checker: RTL and testbench

Response compactor and verdict stage that sits directly downstream of the BIST controller FSM. While the controller holds `running` high, the block folds the circuit-under-test response word into a multiple-input signature register (MISR) on every cycle the controller's `out` strobe is high. When `bist_end` is seen, it compares the final signature with a compiled-in golden value and holds a pass/fail verdict until the next BIST run starts.

---
 rtl/misr_pkg.sv | 18 +
 rtl/misr_core.sv | 45 ++++
 rtl/misr_checker.sv | 156 +++++++++++++++
 tb/tb_misr_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// Shared constants for the MISR response compactor: FSM state encoding and
// default polynomial, seed, golden signature and expected strobe count.
package misr_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPACT = 2'd1;
    localparam logic [1:0] ST_COMPARE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [15:0] MISR_POLY_DEF   = 16'h1021;
    localparam logic [15:0] MISR_SEED_DEF   = 16'h0000;
    localparam logic [15:0] MISR_GOLDEN_DEF = 16'h0000;

    // 6 periods x 12 sequences from the upstream BIST controller
    localparam int unsigned MISR_EXP_CYCLES_DEF = 72;
    localparam int unsigned MISR_CW_DEF         = 8;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register. Shifts left with MSB feedback into the
// POLY taps and XORs the response word in. A load takes priority over a shift.
module misr_core
    import misr_pkg::*;
#(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    POLY = MISR_POLY_DEF,
    parameter logic [W-1:0]    SEED = MISR_SEED_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         shift,
    input  logic [W-1:0] resp,
    output logic [W-1:0] signature
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;
    logic [W-1:0] sig_next;

    // Next signature: load seed, or fold the response word into the register
    always_comb begin
        sig_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ resp;
        sig_d    = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (shift) begin
            sig_d = sig_next;
        end
    end

    // Signature register, returns to SEED on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/misr_checker.sv
// BIST response compactor and verdict stage.
// Folds resp into a MISR on every en strobe while the controller runs, then
// compares against GOLDEN on bist_end and holds done/pass/fail until the next
// rising edge of running.
// Optional build macro MISR_CYCLE_CHECK_EN: adds a saturating strobe counter
// and makes pass also require count == EXP_CYCLES.
//
// state   | meaning
// IDLE    | waiting for a rising edge of running
// COMPACT | folding resp into the MISR on each en
// COMPARE | one cycle to register the verdict
// DONE    | verdict and signature frozen until a new run
module misr_checker
    import misr_pkg::*;
#(
    parameter int unsigned  W          = 16,
    parameter logic [W-1:0] POLY       = MISR_POLY_DEF,
    parameter logic [W-1:0] SEED       = MISR_SEED_DEF,
    parameter logic [W-1:0] GOLDEN     = MISR_GOLDEN_DEF,
    parameter int unsigned  EXP_CYCLES = MISR_EXP_CYCLES_DEF,
    parameter int unsigned  CW         = MISR_CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         running,
    input  logic         bist_end,
    input  logic [W-1:0] resp,
    output logic [W-1:0] signature,
    output logic         done,
    output logic         pass,
    output logic         fail
);

    logic [1:0] state_q, state_d;
    logic       running_q;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       fail_q, fail_d;
    logic       run_start;
    logic       load;
    logic       shift;
    logic       match;
    logic [W-1:0] sig;

    assign run_start = running & ~running_q;

    misr_core #(
        .W    (W),
        .POLY (POLY),
        .SEED (SEED)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .seed      (SEED),
        .shift     (shift),
        .resp      (resp),
        .signature (sig)
    );

`ifdef MISR_CYCLE_CHECK_EN
    localparam logic [CW-1:0] EXP_CNT = CW'(EXP_CYCLES);

    logic [CW-1:0] count_q, count_d;

    // Strobe counter: cleared at run start, saturates instead of wrapping
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (shift && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Strobe counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match = (sig == GOLDEN) && (count_q == EXP_CNT);
`else
    // Count check compiled out; keep the configuration parameters referenced
    logic [CW-1:0] unused_exp_cycles;
    assign unused_exp_cycles = CW'(EXP_CYCLES);

    assign match = (sig == GOLDEN);
`endif

    // FSM next state, MISR control and verdict update
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run_start) begin
                    load    = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    state_d = ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                // an abort cycle must not disturb the held signature
                shift = en & (bist_end | running);
                if (bist_end) begin
                    state_d = ST_COMPARE;
                end else if (!running) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                done_d  = 1'b1;
                pass_d  = match;
                fail_d  = ~match;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, running edge detector and verdict registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
        end
    end

    assign signature = sig;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_misr_checker.sv
// Testbench for misr_checker: a table of single-cycle vectors followed by
// hand-written multi-cycle runs (full good run, short run, faulty response,
// abort, async reset mid-run). Honours MISR_CYCLE_CHECK_EN if defined.
module tb_misr_checker;

`ifdef MISR_CYCLE_CHECK_EN
    localparam bit CYC_CHK = 1'b1;
`else
    localparam bit CYC_CHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic        running;
    logic        bist_end;
    logic [15:0] resp;
    logic [15:0] signature;
    logic        done;
    logic        pass;
    logic        fail;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] model_sig;

    misr_checker dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .running   (running),
        .bist_end  (bist_end),
        .resp      (resp),
        .signature (signature),
        .done      (done),
        .pass      (pass),
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        running;
        logic        bist_end;
        logic        en;
        logic [15:0] resp;
        logic [15:0] exp_sig;
        logic        exp_done;
        logic        exp_pass;
        logic        exp_fail;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [15:0] mstep(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic b, input logic e, input logic [15:0] d);
        running  = r;
        bist_end = b;
        en       = e;
        resp     = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // start a run from IDLE/DONE, compact n words (fault_val at fault_idx),
    // end with bist_end and check the verdict and its stability
    task automatic run_session(input string tag, input int n, input int fault_idx,
                               input logic [15:0] fault_val);
        logic exp_p;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        model_sig = 16'h0000;
        chk({tag, "_start_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_start_sig"}, signature, 16'h0000);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b1, (i == fault_idx) ? fault_val : 16'h0000);
            model_sig = mstep(model_sig, resp);
            step();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        chk({tag, "_k_done"}, {15'd0, done}, 16'd0);
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
        step();
        exp_p = (model_sig == 16'h0000) && (!CYC_CHK || n == 72);
        chk({tag, "_sig"}, signature, model_sig);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_pass"}, {15'd0, pass}, {15'd0, exp_p});
        chk({tag, "_fail"}, {15'd0, fail}, {15'd0, ~exp_p});
        step();
        chk({tag, "_frozen_sig"}, signature, model_sig);
        chk({tag, "_frozen_pass"}, {15'd0, pass}, {15'd0, exp_p});
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h8004, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h1021, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h1021, 16'h3063, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h3063, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 16'h3063, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, !CYC_CHK, CYC_CHK};

        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #12;
        chk("rst_sig", signature, 16'h0000);
        chk("rst_verdict", {13'd0, done, pass, fail}, 16'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].running, vecs[i].bist_end, vecs[i].en, vecs[i].resp);
            step();
            chk($sformatf("vec%0d_sig", i), signature, vecs[i].exp_sig);
            chk($sformatf("vec%0d_done", i), {15'd0, done}, {15'd0, vecs[i].exp_done});
            chk($sformatf("vec%0d_pass", i), {15'd0, pass}, {15'd0, vecs[i].exp_pass});
            chk($sformatf("vec%0d_fail", i), {15'd0, fail}, {15'd0, vecs[i].exp_fail});
        end

        run_session("good", 72, -1, 16'h0000);
        run_session("short", 71, -1, 16'h0000);
        run_session("fault", 72, 10, 16'h0004);
        chk("fault_sig_nonzero", {15'd0, (signature != 16'h0000)}, 16'd1);

        // abort mid-run: running drops without bist_end
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        model_sig = 16'h0000;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'(i * 7 + 1));
            model_sig = mstep(model_sig, resp);
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 16'hFFFF);
        step();
        chk("abort_sig_held", signature, model_sig);
        chk("abort_done", {15'd0, done}, 16'd0);
        drive(1'b0, 1'b1, 1'b1, 16'h1234);
        step();
        step();
        chk("idle_en_ignored", signature, model_sig);
        chk("idle_bist_end_ignored", {15'd0, done}, 16'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        chk("restart_seed", signature, 16'h0000);

        // async reset between edges while compacting
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'h00A5);
            step();
        end
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_sig", signature, 16'h0000);
        chk("async_rst_verdict", {13'd0, done, pass, fail}, 16'd0);
        #2;
        reset = 1'b1;
        run_session("after_rst", 72, -1, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
